// File: rtl/conv_output_collector_if.sv
// Result stream (accelerator -> collector) and replay stream (collector -> host).
// The master drives samples and consumes the replay; the slave is the collector.
interface conv_output_collector_if #(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 8,
  parameter int FEATURE_MAP_HEIGHT = 8,
  parameter int OUTPUT_NB_CHANNELS = 4
);
  localparam int XW = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CW = $clog2(OUTPUT_NB_CHANNELS);

  logic signed [DATA_WIDTH-1:0] output_data;
  logic                         output_valid;
  logic [XW-1:0]                output_x;
  logic [YW-1:0]                output_y;
  logic [CW-1:0]                output_ch;

  logic signed [DATA_WIDTH-1:0] rd_data;
  logic                         rd_valid;
  logic                         rd_ready;
  logic                         rd_last;

  modport master (
    output output_data, output_valid, output_x, output_y, output_ch, rd_ready,
    input  rd_data, rd_valid, rd_last
  );

  modport slave (
    input  output_data, output_valid, output_x, output_y, output_ch, rd_ready,
    output rd_data, rd_valid, rd_last
  );
endinterface

// File: rtl/conv_output_collector.sv
// Captures accelerator output pixels in any order into a local frame buffer,
// flags protocol errors, then replays the frame in ascending address order.
module conv_output_collector #(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 8,
  parameter int FEATURE_MAP_HEIGHT = 8,
  parameter int OUTPUT_NB_CHANNELS = 4,
  localparam int NB_ELEMS = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS,
  localparam int AW       = $clog2(NB_ELEMS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  conv_output_collector_if.slave bus,
  output logic                   collecting,
  output logic                   done,
  output logic [AW-1:0]          count,
  output logic                   dup_error,
  output logic                   range_error,
  output logic                   late_error
);
  localparam int PW = (NB_ELEMS > 1) ? $clog2(NB_ELEMS) : 1;
  localparam logic [AW-1:0] LAST_COUNT = AW'(NB_ELEMS - 1);
  localparam logic [PW-1:0] LAST_ADDR  = PW'(NB_ELEMS - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic signed [DATA_WIDTH-1:0] mem [NB_ELEMS];
  logic [NB_ELEMS-1:0]          bitmap;

  logic [PW-1:0]                wr_addr;
  logic [PW-1:0]                rd_ptr;
  logic [PW-1:0]                rd_ptr_next;
  logic                         in_range;
  logic                         seen;
  logic                         capture;
  logic                         frame_full;
  logic                         handshake;

  logic signed [DATA_WIDTH-1:0] rd_data_q;
  logic                         rd_valid_q;
  logic                         rd_last_q;

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign collecting   = (state == COLLECT);

  always_comb begin
    in_range = (int'(bus.output_x)  < FEATURE_MAP_WIDTH)  &&
               (int'(bus.output_y)  < FEATURE_MAP_HEIGHT) &&
               (int'(bus.output_ch) < OUTPUT_NB_CHANNELS);
    wr_addr  = (PW'(bus.output_ch) * PW'(FEATURE_MAP_HEIGHT) + PW'(bus.output_y))
               * PW'(FEATURE_MAP_WIDTH) + PW'(bus.output_x);
    seen        = bitmap[wr_addr];
    rd_ptr_next = rd_ptr + PW'(1);
    capture     = (state == COLLECT) && bus.output_valid && in_range && !seen && !start;
    frame_full  = capture && (count == LAST_COUNT);
    handshake   = (state == DRAIN) && rd_valid_q && bus.rd_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = IDLE;
      COLLECT: if (frame_full) state_next = DRAIN;
      DRAIN:   if (handshake && rd_last_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (start) begin
      state_next = COLLECT;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_addr] <= bus.output_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap      <= '0;
      count       <= '0;
      done        <= 1'b0;
      dup_error   <= 1'b0;
      range_error <= 1'b0;
      late_error  <= 1'b0;
      rd_ptr      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else if (start) begin
      bitmap      <= '0;
      count       <= '0;
      done        <= 1'b0;
      dup_error   <= 1'b0;
      range_error <= 1'b0;
      late_error  <= 1'b0;
      rd_ptr      <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      if (bus.output_valid) begin
        if (state != COLLECT) begin
          late_error <= 1'b1;
        end else if (!in_range) begin
          range_error <= 1'b1;
        end else if (seen) begin
          dup_error <= 1'b1;
        end
      end

      if (capture) begin
        bitmap[wr_addr] <= 1'b1;
        count           <= count + AW'(1);
      end

      // Element 0 may be the very sample completing the frame: forward it
      // so the first replay word is valid one cycle after the last capture.
      if (frame_full) begin
        rd_valid_q <= 1'b1;
        rd_ptr     <= '0;
        rd_last_q  <= (NB_ELEMS == 1);
        rd_data_q  <= (wr_addr == '0) ? bus.output_data : mem[0];
      end

      if (handshake) begin
        if (rd_last_q) begin
          rd_valid_q <= 1'b0;
          rd_last_q  <= 1'b0;
          done       <= 1'b1;
        end else begin
          rd_ptr    <= rd_ptr_next;
          rd_data_q <= mem[rd_ptr_next];
          rd_last_q <= (rd_ptr_next == LAST_ADDR);
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_output_collector.sv
// Randomized scoreboard bench for conv_output_collector: a frame-level
// reference model queues the expected replay, a monitor consumes it.
module tb_conv_output_collector;
  localparam int DW  = 16;
  localparam int W   = 8;
  localparam int H   = 8;
  localparam int C   = 4;
  localparam int NB  = W * H * C;
  localparam int XW  = $clog2(W);
  localparam int YW  = $clog2(H);
  localparam int CW  = $clog2(C);
  localparam int AW  = $clog2(NB + 1);
  localparam int W2  = 6;
  localparam int NB2 = W2 * H * C;
  localparam int XW2 = $clog2(W2);
  localparam int AW2 = $clog2(NB2 + 1);

  typedef struct {
    logic signed [DW-1:0] data;
    logic                 last;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;

  logic          collecting, done, dup_error, range_error, late_error;
  logic [AW-1:0] count;
  logic           collecting2, done2, dup_error2, range_error2, late_error2;
  logic [AW2-1:0] count2;

  conv_output_collector_if #(.DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W),
    .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(C)) bus ();
  conv_output_collector_if #(.DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W2),
    .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(C)) bus2 ();

  conv_output_collector #(.DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W),
    .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .collecting(collecting), .done(done), .count(count),
    .dup_error(dup_error), .range_error(range_error), .late_error(late_error)
  );

  conv_output_collector #(.DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W2),
    .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(C)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bus(bus2),
    .collecting(collecting2), .done(done2), .count(count2),
    .dup_error(dup_error2), .range_error(range_error2), .late_error(late_error2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int ready_mode = 3;

  item_t sb[$];
  logic signed [DW-1:0] ref_mem [NB];
  bit ref_wr [NB];
  int ref_cnt;
  bit ref_coll;
  bit exp_dup, exp_range, exp_late;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready generator runs just after the stimulus slot in each cycle.
  initial begin : ready_gen
    int unsigned cyc;
    cyc = 0;
    bus.rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      case (ready_mode)
        0:       bus.rd_ready = 1'b1;
        1:       bus.rd_ready = (cyc % 3 == 0);
        2:       bus.rd_ready = 1'($urandom % 2);
        default: bus.rd_ready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    item_t it;
    logic stalled;
    logic signed [DW-1:0] held_data;
    logic held_last;
    stalled = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rd_valid && bus.rd_ready) begin
        hs_count++;
        if (sb.size() == 0) begin
          check("replay_unexpected", 32'(bus.rd_data), 32'hdead_beef);
        end else begin
          it = sb.pop_front();
          check("replay_data", 32'(bus.rd_data), 32'(it.data));
          check("replay_last", 32'(bus.rd_last), 32'(it.last));
        end
        stalled = 1'b0;
      end else if (bus.rd_valid) begin
        if (stalled) begin
          check("stall_data", 32'(bus.rd_data), 32'(held_data));
          check("stall_last", 32'(bus.rd_last), 32'(held_last));
        end
        stalled   = 1'b1;
        held_data = bus.rd_data;
        held_last = bus.rd_last;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic do_start();
    ready_mode = 3;
    start = 1'b1;
    sb.delete();
    for (int i = 0; i < NB; i++) ref_wr[i] = 1'b0;
    ref_cnt  = 0;
    ref_coll = 1'b1;
    exp_dup = 1'b0; exp_range = 1'b0; exp_late = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int x, input int y, input int ch, input logic signed [DW-1:0] d);
    int a;
    bus.output_valid = 1'b1;
    bus.output_x     = XW'(x);
    bus.output_y     = YW'(y);
    bus.output_ch    = CW'(ch);
    bus.output_data  = d;
    if (!ref_coll) begin
      exp_late = 1'b1;
    end else if (x >= W || y >= H || ch >= C) begin
      exp_range = 1'b1;
    end else begin
      a = (ch * H + y) * W + x;
      if (ref_wr[a]) begin
        exp_dup = 1'b1;
      end else begin
        ref_wr[a]  = 1'b1;
        ref_mem[a] = d;
        ref_cnt++;
        if (ref_cnt == NB) begin
          ref_coll = 1'b0;
          for (int k = 0; k < NB; k++) sb.push_back('{ref_mem[k], k == NB - 1});
        end
      end
    end
    @(posedge clk); #1;
    bus.output_valid = 1'b0;
  endtask

  // kind: 0 raster with data=addr, 1 reverse order, 2 shuffled; random data for 1/2.
  task automatic run_frame(input int kind, input int rmode, input bit inject);
    int order [NB];
    int tmp, j, a;
    logic signed [DW-1:0] d;
    for (int i = 0; i < NB; i++) order[i] = (kind == 1) ? NB - 1 - i : i;
    if (kind == 2) begin
      for (int i = NB - 1; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
    end
    if (inject) begin
      for (int i = 0; i < NB; i++) begin
        if (order[i] == 83) begin
          order[i] = order[10]; order[10] = 83;
        end
      end
    end
    do_start();
    hs_count = 0;
    check("start_collecting", 32'(collecting), 32'd1);
    check("start_count", 32'(count), 32'd0);
    ready_mode = rmode;
    for (int i = 0; i < NB; i++) begin
      a = order[i];
      d = (kind == 0) ? DW'(a) : DW'($urandom);
      if (inject && a == 83) d = 16'sh0011;
      send(a % W, (a / W) % H, a / (W * H), d);
      if (inject && a == 83) begin
        send(3, 2, 1, 16'sh0022);
        check("dup_flag", 32'(dup_error), 32'd1);
        check("dup_count", 32'(count), 32'(ref_cnt));
      end
    end
    check("drain_latency_valid", 32'(bus.rd_valid), 32'd1);
    check("drain_collecting", 32'(collecting), 32'd0);
    check("full_count", 32'(count), 32'(NB));
  endtask

  task automatic finish_frame();
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("done", 32'(done), 32'd1);
    check("replay_remaining", 32'(sb.size()), 32'd0);
    check("end_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("end_dup", 32'(dup_error), 32'(exp_dup));
    check("end_range", 32'(range_error), 32'(exp_range));
    check("end_late", 32'(late_error), 32'(exp_late));
    check("end_count", 32'(count), 32'(ref_cnt));
  endtask

  task automatic send2(input int x, input int y, input int ch);
    bus2.output_valid = 1'b1;
    bus2.output_x     = XW2'(x);
    bus2.output_y     = YW'(y);
    bus2.output_ch    = CW'(ch);
    bus2.output_data  = DW'($urandom);
    @(posedge clk); #1;
    bus2.output_valid = 1'b0;
  endtask

  initial begin : stimulus
    int guard;
    bus.output_valid = 1'b0; bus.output_data = '0;
    bus.output_x = '0; bus.output_y = '0; bus.output_ch = '0;
    bus2.output_valid = 1'b0; bus2.output_data = '0;
    bus2.output_x = '0; bus2.output_y = '0; bus2.output_ch = '0;
    bus2.rd_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_collecting", 32'(collecting), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_errors", 32'({dup_error, range_error, late_error}), 32'd0);
    check("rst_rd", 32'({bus.rd_valid, bus.rd_last, bus.rd_data}), 32'd0);

    run_frame(0, 0, 1'b0); finish_frame();
    run_frame(1, 0, 1'b0); finish_frame();
    run_frame(2, 2, 1'b1); finish_frame();
    run_frame(2, 1, 1'b0); finish_frame();

    run_frame(2, 0, 1'b1);
    guard = 0;
    while (hs_count < 10 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("abort_handshakes", 32'(hs_count), 32'd10);
    check("abort_pending", 32'(sb.size()), 32'(NB - 10));
    do_start();
    check("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("abort_count", 32'(count), 32'd0);
    check("abort_errors", 32'({dup_error, range_error, late_error}), 32'd0);
    check("abort_collecting", 32'(collecting), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_more_hs", 32'(hs_count), 32'd10);

    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("w6_collecting", 32'(collecting2), 32'd1);
    send2(7, 0, 0);
    check("w6_range_x7", 32'(range_error2), 32'd1);
    check("w6_count_after_x7", 32'(count2), 32'd0);
    send2(5, 7, 3);
    check("w6_count_edge", 32'(count2), 32'd1);
    check("w6_no_dup", 32'(dup_error2), 32'd0);
    send2(6, 1, 1);
    check("w6_count_after_x6", 32'(count2), 32'd1);
    check("w6_range_sticky", 32'(range_error2), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("w6_rst_state", 32'({collecting2, done2, dup_error2, range_error2, late_error2}), 32'd0);
    check("w6_rst_count", 32'(count2), 32'd0);
    check("w6_rst_rd", 32'({bus2.rd_valid, bus2.rd_last, bus2.rd_data}), 32'd0);
    send2(1, 1, 1);
    check("w6_late", 32'(late_error2), 32'd1);
    check("w6_late_count", 32'(count2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
